am_error_sweep: RTL and testbench

Exhaustive error-characterisation sequencer for one approximate unsigned WIDTHxWIDTH multiplier instance.
- Drives every operand pair into the external multiplier, one pair per cycle.
- Compares each result against an internally computed exact product and accumulates error statistics in hardware.
- Used on FPGA/emulation to confirm approximate-multiplier error metrics (error rate, max, mean, bias) without streaming 2^(2*WIDTH) results off-chip.

---
 rtl/am_error_sweep_if.sv | 11 +
 rtl/am_error_sweep.sv | 150 +++++++++++++++
 tb/tb_am_error_sweep.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/am_error_sweep_if.sv
// Operand/product bus between the sweep sequencer and the approximate multiplier under test.
interface am_error_sweep_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0]   mul_x;
   logic [WIDTH-1:0]   mul_y;
   logic [2*WIDTH-1:0] mul_z;

   modport master (output mul_x, output mul_y, input mul_z);
   modport slave  (input mul_x, input mul_y, output mul_z);
endinterface

// File: rtl/am_error_sweep.sv
// Exhaustive operand sweep of an external approximate multiplier, accumulating
// error count, max/sum of absolute error and signed error sum against the exact product.
//
// state   | meaning
// S_IDLE  | results held; start clears stats and begins a sweep
// S_RUN   | one operand pair issued per cycle
// S_DRAIN | waiting for the product/diff pipeline to empty
// S_DONE  | one-cycle done pulse, results final
module am_error_sweep #(
   parameter int WIDTH   = 8,
   parameter int MUL_LAT = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic                 abort_i,
   output logic                 busy_o,
   output logic                 done_o,
   am_error_sweep_if.master     mul,
   output logic [2*WIDTH:0]     err_count_o,
   output logic [2*WIDTH-1:0]   max_abs_err_o,
   output logic [4*WIDTH-1:0]   sum_abs_err_o,
   output logic [4*WIDTH:0]     sum_err_o
);
   localparam int PW = 2*WIDTH;
   localparam logic [PW-1:0] CNT_ONE = {{(PW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic              issue_v, flush, clr, last, pipe_busy;
   logic [PW-1:0]     cnt_q, cnt_nxt;
   logic [WIDTH-1:0]  mul_x_q, mul_y_q;
   logic [PW-1:0]     exact_c, ex_al;
   logic              v_al;
   logic [PW:0]       diff_q, abs_diff;
   logic              diff_v_q;
   logic [PW:0]       err_q;
   logic [PW-1:0]     max_q;
   logic [4*WIDTH-1:0] sabs_q;
   logic [4*WIDTH:0]  serr_q;

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   assign last = (cnt_q == '1);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_i) state_d = S_RUN;
         S_RUN:   if (abort_i) state_d = S_IDLE;
                  else if (last) state_d = S_DRAIN;
         S_DRAIN: if (abort_i) state_d = S_IDLE;
                  else if (!pipe_busy) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy_o  = (state_q == S_RUN) || (state_q == S_DRAIN);
      done_o  = (state_q == S_DONE);
      issue_v = (state_q == S_RUN);
      flush   = abort_i && ((state_q == S_RUN) || (state_q == S_DRAIN));
      clr     = (state_q == S_IDLE) && start_i;
   end

   assign cnt_nxt   = cnt_q + CNT_ONE;
   assign exact_c   = {{WIDTH{1'b0}}, mul_x_q} * {{WIDTH{1'b0}}, mul_y_q};
   assign mul.mul_x = mul_x_q;
   assign mul.mul_y = mul_y_q;

   // Exact product travels alongside the multiplier's own latency so both sides meet at mul_z.
   generate
      if (MUL_LAT == 0) begin : g_nolat
         assign ex_al     = exact_c;
         assign v_al      = issue_v;
         assign pipe_busy = 1'b0;
      end else begin : g_lat
         logic [PW-1:0]      ex_q [MUL_LAT];
         logic [MUL_LAT-1:0] v_q;

         always_ff @(posedge clk) begin
            if (rst || flush) begin
               v_q <= '0;
            end else begin
               v_q[0] <= issue_v;
               for (int i = 1; i < MUL_LAT; i++) v_q[i] <= v_q[i-1];
            end
            ex_q[0] <= exact_c;
            for (int i = 1; i < MUL_LAT; i++) ex_q[i] <= ex_q[i-1];
         end

         assign ex_al     = ex_q[MUL_LAT-1];
         assign v_al      = v_q[MUL_LAT-1];
         assign pipe_busy = |v_q;
      end
   endgenerate

   assign abs_diff = diff_q[PW] ? (-diff_q) : diff_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         mul_x_q  <= '0;
         mul_y_q  <= '0;
         diff_q   <= '0;
         diff_v_q <= 1'b0;
         err_q    <= '0;
         max_q    <= '0;
         sabs_q   <= '0;
         serr_q   <= '0;
      end else begin
         if (clr) begin
            cnt_q   <= '0;
            mul_x_q <= '0;
            mul_y_q <= '0;
         end else if (issue_v) begin
            cnt_q <= cnt_nxt;
            if (!last) begin
               mul_x_q <= cnt_nxt[PW-1:WIDTH];
               mul_y_q <= cnt_nxt[WIDTH-1:0];
            end
         end

         diff_q   <= {1'b0, ex_al} - {1'b0, mul.mul_z};
         diff_v_q <= v_al && !flush;

         if (clr) begin
            err_q  <= '0;
            max_q  <= '0;
            sabs_q <= '0;
            serr_q <= '0;
         end else if (diff_v_q) begin
            err_q  <= err_q + {{PW{1'b0}}, |diff_q};
            if (abs_diff > {1'b0, max_q}) max_q <= abs_diff[PW-1:0];
            sabs_q <= sabs_q + {{(PW-1){1'b0}}, abs_diff};
            serr_q <= serr_q + {{PW{diff_q[PW]}}, diff_q};
         end
      end
   end

   assign err_count_o   = err_q;
   assign max_abs_err_o = max_q;
   assign sum_abs_err_o = sabs_q;
   assign sum_err_o     = serr_q;
endmodule

// File: tb/tb_am_error_sweep.sv
// Bench for am_error_sweep: two instances (latency 0 and 2) sweep table-driven multiplier stubs,
// results compared to statistics computed directly from the stub table.
module tb_am_error_sweep;
   localparam int W = 4;
   localparam int N = 1 << (2*W);
   localparam int M = (1 << W) - 1;

   logic clk = 1'b0;
   logic rst, start, abort;
   always #5 clk = ~clk;

   logic [2*W-1:0] tab [N];

   am_error_sweep_if #(.WIDTH(W)) mif0 ();
   am_error_sweep_if #(.WIDTH(W)) mif2 ();

   logic busy0, done0, busy2, done2;
   logic [2*W:0]   err0, err2;
   logic [2*W-1:0] max0, max2;
   logic [4*W-1:0] sabs0, sabs2;
   logic [4*W:0]   serr0, serr2;

   am_error_sweep #(.WIDTH(W), .MUL_LAT(0)) dut0 (
      .clk(clk), .rst(rst), .start_i(start), .abort_i(abort),
      .busy_o(busy0), .done_o(done0), .mul(mif0),
      .err_count_o(err0), .max_abs_err_o(max0),
      .sum_abs_err_o(sabs0), .sum_err_o(serr0)
   );

   am_error_sweep #(.WIDTH(W), .MUL_LAT(2)) dut2 (
      .clk(clk), .rst(rst), .start_i(start), .abort_i(abort),
      .busy_o(busy2), .done_o(done2), .mul(mif2),
      .err_count_o(err2), .max_abs_err_o(max2),
      .sum_abs_err_o(sabs2), .sum_err_o(serr2)
   );

   // Stub multipliers: combinational lookup, and a two-stage registered lookup.
   logic [2*W-1:0] z2_r1, z2_r2;
   assign mif0.mul_z = tab[{mif0.mul_x, mif0.mul_y}];
   always @(posedge clk) begin
      z2_r1 <= tab[{mif2.mul_x, mif2.mul_y}];
      z2_r2 <= z2_r1;
   end
   assign mif2.mul_z = z2_r2;

   int n_vec = 0;
   int n_err = 0;
   longint e_cnt, e_max, e_sabs, e_serr;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // mode: 0 exact, 1 zero, 2 exact+1, 3 low half cleared, 4 random errors, 5 keep table
   task automatic fill_tab(input int mode);
      for (int i = 0; i < N; i++) begin
         int p, v, r;
         p = (i >> W) * (i & M);
         v = p;
         case (mode)
            1: v = 0;
            2: v = p + 1;
            3: v = p & ((N - 1) ^ M);
            4: begin
               r = int'($urandom_range(0, 3));
               if (r == 2) v = p ^ int'($urandom_range(1, N - 1));
               else if (r == 3) v = int'($urandom_range(0, N - 1));
            end
            default: v = p;
         endcase
         if (mode != 5) tab[i] = v[2*W-1:0];
      end
   endtask

   task automatic build_model();
      e_cnt = 0; e_max = 0; e_sabs = 0; e_serr = 0;
      for (int i = 0; i < N; i++) begin
         longint d, ad;
         d  = longint'((i >> W) * (i & M)) - longint'(tab[i]);
         ad = (d < 0) ? -d : d;
         if (d != 0) e_cnt++;
         if (ad > e_max) e_max = ad;
         e_sabs += ad;
         e_serr += d;
      end
   endtask

   task automatic check_stats(input string tag);
      chk({tag, " cnt0"},  longint'(err0),  e_cnt);
      chk({tag, " max0"},  longint'(max0),  e_max);
      chk({tag, " sabs0"}, longint'(sabs0), e_sabs);
      chk({tag, " serr0"}, longint'($signed(serr0)), e_serr);
      chk({tag, " cnt2"},  longint'(err2),  e_cnt);
      chk({tag, " max2"},  longint'(max2),  e_max);
      chk({tag, " sabs2"}, longint'(sabs2), e_sabs);
      chk({tag, " serr2"}, longint'($signed(serr2)), e_serr);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, " busy0"}, longint'(busy0), 0);
      chk({tag, " done0"}, longint'(done0), 0);
      chk({tag, " x0"},    longint'(mif0.mul_x), 0);
      chk({tag, " y0"},    longint'(mif0.mul_y), 0);
      chk({tag, " busy2"}, longint'(busy2), 0);
      chk({tag, " done2"}, longint'(done2), 0);
      chk({tag, " x2"},    longint'(mif2.mul_x), 0);
      chk({tag, " y2"},    longint'(mif2.mul_y), 0);
      e_cnt = 0; e_max = 0; e_sabs = 0; e_serr = 0;
      check_stats(tag);
   endtask

   task automatic run_sweep(input string tag, input int mode, input int abort_at,
                            input int restart_at, input int rst_at);
      int d_at0, d_at2, nd0, nd2, idx;
      fill_tab(mode);
      build_model();
      d_at0 = 0; d_at2 = 0; nd0 = 0; nd2 = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= N + 12; k++) begin
         if (k == 1) begin
            chk({tag, " busy0 first"}, longint'(busy0), 1);
            chk({tag, " busy2 first"}, longint'(busy2), 1);
         end
         if (k <= N + 1 && (abort_at == 0 || k <= abort_at)) begin
            idx = (k <= N) ? k - 1 : N - 1;
            chk({tag, " x0"}, longint'(mif0.mul_x), idx >> W);
            chk({tag, " y0"}, longint'(mif0.mul_y), idx & M);
            chk({tag, " x2"}, longint'(mif2.mul_x), idx >> W);
            chk({tag, " y2"}, longint'(mif2.mul_y), idx & M);
         end
         if (done0) begin
            nd0++; d_at0 = k;
            chk({tag, " busy0 at done"}, longint'(busy0), 0);
         end
         if (done2) begin
            nd2++; d_at2 = k;
            chk({tag, " busy2 at done"}, longint'(busy2), 0);
         end
         if (abort_at != 0 && k == abort_at + 1) begin
            chk({tag, " busy0 after abort"}, longint'(busy0), 0);
            chk({tag, " busy2 after abort"}, longint'(busy2), 0);
            abort = 1'b0;
         end
         if (k == abort_at) abort = 1'b1;
         if (restart_at != 0 && k == restart_at + 1) start = 1'b0;
         if (k == restart_at) start = 1'b1;
         if (rst_at != 0 && k == rst_at + 1) begin
            check_zero({tag, " after rst"});
            rst = 1'b0;
         end
         if (k == rst_at) rst = 1'b1;
         @(posedge clk); #1;
      end
      chk({tag, " busy0 end"}, longint'(busy0), 0);
      chk({tag, " busy2 end"}, longint'(busy2), 0);
      if (abort_at != 0) begin
         chk({tag, " done0 count"}, nd0, 0);
         chk({tag, " done2 count"}, nd2, 0);
      end else if (rst_at == 0) begin
         chk({tag, " done0 count"}, nd0, 1);
         chk({tag, " done2 count"}, nd2, 1);
         chk({tag, " done0 cycle"}, d_at0, N + 2);
         chk({tag, " done2 cycle"}, d_at2, N + 4);
         check_stats(tag);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      fill_tab(0);
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b0;

      run_sweep("exact",   0, 0,   0,  0);
      run_sweep("zero",    1, 0,   0,  0);
      run_sweep("plus1",   2, 0,   0,  0);
      run_sweep("lowmask", 3, 0,   0,  0);
      run_sweep("abort",   4, 100, 0,  0);
      run_sweep("restart", 4, 0,   50, 0);
      run_sweep("rand",    4, 0,   0,  0);
      run_sweep("drainrst", 4, 0,  0,  N + 2);
      run_sweep("afterrst", 5, 0,  0,  0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
